// File: rtl/inst_fetch_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset PC and the
// {pc, inst} record carried through the prefetch buffer.
package inst_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low byte-offset bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction ROM read port plus the decode
// valid/ready handshake. master = fetch unit, slave = ROM/decode side.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;

  modport master (
    output rom_addr,
    input  rom_inst,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc
  );

  modport slave (
    input  rom_addr,
    output rom_inst,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc
  );

endinterface

// File: rtl/inst_fetch_checker.sv
// Structural invariants of the fetch front end, kept apart from the datapath.
module inst_fetch_checker
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   redirect_valid,
  input logic [$clog2(DEPTH):0] count,
  input logic [ADDR_W-1:0]      pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    pc[1:0] == 2'b00);

  a_redirect_flushes: assert property (@(posedge clk) disable iff (!rst_n)
    redirect_valid |=> (count == {CNT_W{1'b0}}));

endmodule

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t records. Power-of-two DEPTH so pointers wrap
// naturally; flush acts as a synchronous clear of pointers and count.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic                     full_s;
  logic                     empty_s;
  logic                     wr_en_s;
  logic                     rd_en_s;

  // Status flags and qualified enables; full is judged on the pre-pop count.
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (flush) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = push && !full_s;
      rd_en_s = pop && !empty_s;
    end
  end

  // Entry storage, cleared on hard reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_s;
  assign empty   = empty_s;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC register driving a combinational ROM,
// a prefetch FIFO toward decode, and branch/jump redirect with flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_fetch_if.master           bus,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [ADDR_W-1:0] pc_r;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  fetch_entry_t      wr_entry_s;
  fetch_entry_t      head_s;

  // A redirect cycle neither fetches nor hands anything to decode.
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    wr_entry_s = '{pc: pc_r, inst: bus.rom_inst};
    if (redirect_valid) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = fetch_en && !full_s;
      pop_s  = !empty_s && bus.id_ready;
    end
  end

  // Program counter: redirect target wins, otherwise advance on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= align_word(redirect_pc);
    end else if (push_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  inst_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wr_entry_s),
    .rd_data (head_s),
    .count   (fifo_count),
    .full    (full_s),
    .empty   (empty_s)
  );

  inst_fetch_checker #(
    .DEPTH (DEPTH)
  ) u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .count          (fifo_count),
    .pc             (pc_r)
  );

  assign bus.rom_addr = pc_r;
  assign bus.id_valid = !empty_s && !redirect_valid;
  assign bus.id_pc    = head_s.pc;
  assign bus.id_inst  = head_s.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: ROM word k = 32'h1000_0000 + k, and a
// queue-based reference model of the prefetch buffer.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] fifo_count;

  inst_fetch_if bus();

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mq[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  assign bus.rom_inst = 32'h1000_0000 + (bus.rom_addr >> 2);

  inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  // Advance the reference model by one clock using the inputs now applied.
  task automatic tick();
    bit was_full;
    was_full = (mq.size() == DEPTH);
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (mq.size() > 0 && bus.id_ready) void'(mq.pop_front());
      if (fetch_en && !was_full) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.id_ready = 1'b0;
    mq.delete();
    m_pc = RST_PC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en = 1'b1;
    redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    n_cmp++; if (bus.rom_addr !== RST_PC) begin n_err++; $display("FAIL reset_rom_addr: got %h want %h", bus.rom_addr, RST_PC); end
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    n_cmp++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0) begin n_err++; $display("FAIL reset_head: got pc %h inst %h want 0/0", bus.id_pc, bus.id_inst); end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (bus.rom_addr !== m_pc) begin n_err++; $display("FAIL stream_rom_addr: got %h want %h", bus.rom_addr, m_pc); end
      n_cmp++; if (fifo_count !== CW'(mq.size())) begin n_err++; $display("FAIL stream_count: got %0d want %0d", fifo_count, mq.size()); end
      if (i > 0) begin
        n_cmp++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * (i - 1)) || bus.id_inst !== 32'h1000_0000 + 32'(i - 1))
          begin n_err++; $display("FAIL stream_head: got v%b pc %h inst %h want pc %h", bus.id_valid, bus.id_pc, bus.id_inst, 32'(4 * (i - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (fifo_count !== CW'(mq.size()) || bus.rom_addr !== m_pc) begin n_err++; $display("FAIL stall_fill: got cnt %0d addr %h want %0d %h", fifo_count, bus.rom_addr, mq.size(), m_pc); end
      tick();
    end
    #1;
    n_cmp++; if (fifo_count !== CW'(4) || bus.rom_addr !== 32'h10) begin n_err++; $display("FAIL stall_saturate: got cnt %0d addr %h want 4 00000010", fifo_count, bus.rom_addr); end
    bus.id_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if (fifo_count !== CW'(3) || bus.rom_addr !== 32'h10 || bus.id_pc !== 32'h4) begin n_err++; $display("FAIL full_pop_no_push: got cnt %0d addr %h head %h want 3 10 4", fifo_count, bus.rom_addr, bus.id_pc); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) #1;
      n_cmp++;
      if (fifo_count !== CW'(mq.size()) || bus.rom_addr !== m_pc || bus.id_pc !== mq[0] || bus.id_inst !== rom_word(mq[0]))
        begin n_err++; $display("FAIL stall_drain: got cnt %0d addr %h head %h want %0d %h %h", fifo_count, bus.rom_addr, bus.id_pc, mq.size(), m_pc, mq[0]); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    #1;
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL redirect_valid_low: got %b want 0", bus.id_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fifo_count !== CW'(0) || bus.rom_addr !== 32'h200) begin n_err++; $display("FAIL redirect_flush: got cnt %0d addr %h want 0 00000200", fifo_count, bus.rom_addr); end
    bus.id_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200 || bus.id_inst !== 32'h1000_0080) begin n_err++; $display("FAIL redirect_target: got v%b pc %h inst %h want 1 200 10000080", bus.id_valid, bus.id_pc, bus.id_inst); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.rom_addr !== 32'h0 || fifo_count !== CW'(1) || bus.id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got addr %h cnt %0d head %h want 0 1 fffffffc", bus.rom_addr, fifo_count, bus.id_pc); end
    tick();
    bus.id_ready = 1'b1;
    #1;
    n_cmp++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_inst !== 32'h4FFF_FFFF) begin n_err++; $display("FAIL wrap_first: got pc %h inst %h want fffffffc 4fffffff", bus.id_pc, bus.id_inst); end
    tick();
    #1;
    n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h1000_0000) begin n_err++; $display("FAIL wrap_second: got v%b pc %h inst %h want 1 0 10000000", bus.id_valid, bus.id_pc, bus.id_inst); end
  endtask

  task automatic test_random();
    bit exp_valid;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      bus.id_ready   = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      #1;
      exp_valid = (mq.size() > 0) && !redirect_valid;
      n_cmp++; if (bus.rom_addr !== m_pc) begin n_err++; $display("FAIL rand_rom_addr @%0d: got %h want %h", i, bus.rom_addr, m_pc); end
      n_cmp++; if (fifo_count !== CW'(mq.size())) begin n_err++; $display("FAIL rand_count @%0d: got %0d want %0d", i, fifo_count, mq.size()); end
      n_cmp++; if (bus.id_valid !== exp_valid) begin n_err++; $display("FAIL rand_id_valid @%0d: got %b want %b", i, bus.id_valid, exp_valid); end
      if (mq.size() > 0) begin
        n_cmp++;
        if (bus.id_pc !== mq[0] || bus.id_inst !== rom_word(mq[0]))
          begin n_err++; $display("FAIL rand_head @%0d: got pc %h inst %h want %h %h", i, bus.id_pc, bus.id_inst, mq[0], rom_word(mq[0])); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    repeat (2) tick();
    #2;
    n_cmp++; if (fifo_count !== CW'(2)) begin n_err++; $display("FAIL areset_pre: got %0d want 2", fifo_count); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== RST_PC || fifo_count !== CW'(0)) begin n_err++; $display("FAIL areset_immediate: got v%b addr %h cnt %0d want 0 %h 0", bus.id_valid, bus.rom_addr, fifo_count, RST_PC); end
    mq.delete();
    m_pc = RST_PC;
    @(negedge clk);
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RST_PC || bus.rom_addr !== RST_PC + 32'd4) begin n_err++; $display("FAIL areset_restart: got v%b pc %h addr %h", bus.id_valid, bus.id_pc, bus.rom_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end that drives the instruction ROM's address port and consumes its combinational instruction output. It holds the program counter, issues one ROM read per cycle, and buffers fetched {pc, inst} pairs in a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. A branch/jump redirect flushes the buffer and restarts fetch at a new PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to instruction ROM; equals current PC.
- rom_inst  in  32  ROM word for rom_addr, valid in the same cycle (combinational ROM).
- fetch_en  in  1  1 = fetch allowed; 0 = hold PC, no push.
- redirect_valid  in  1  flush and load redirect_pc this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- id_valid  out  1  FIFO head available to decode.
- id_ready  in  1  decode accepts head this cycle.
- id_inst  out  32  instruction at FIFO head.
- id_pc  out  32  PC of that instruction.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- rom_addr = pc (combinational from PC register).
- Push condition: fetch_en && !full && !redirect_valid. On push: write {pc, rom_inst} to tail; pc <= pc + 4.
- Full is evaluated on the pre-pop count. No push when count == DEPTH, even if a pop occurs the same cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- id_valid = !empty && !redirect_valid. Pop when id_valid && id_ready.
- id_inst/id_pc show the head entry whenever non-empty. Values are don't-care when empty.
- Redirect has priority over everything. In that cycle:
  - count <= 0 and pointers are reset.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- fetch_en = 0 does not block pops. The FIFO drains normally.
- Reset values (asynchronous on rst_n low):
  - pc = RESET_PC, hence rom_addr = RESET_PC.
  - count = 0, id_valid = 0, fifo_count = 0.
  - id_inst = 0, id_pc = 0, pointers = 0.
  - Reset mid-operation discards all buffered entries immediately.

## Timing
- Fetch-to-decode latency: 1 cycle. The word read at edge N is visible on id_* after edge N.
- First cycle after rst_n deasserts with fetch_en = 1: RESET_PC is pushed, and id_valid = 1 after that edge.
- Steady state with id_ready held 1: one instruction per cycle, FIFO occupancy 1.
- Redirect at edge N:
  - id_valid = 0 during cycle N.
  - redirect_pc is fetched in cycle N+1.
  - Its instruction appears on id_* after edge N+1.
- Sustained throughput with id_ready = 1: 1 instr/cycle. There is no bubble except redirect, and the full-then-pop case yields one lost push slot.

## Structure
- Shared package (cpu defines): INST_W = 32, ADDR_W = 32, default reset PC constant, and a fetch_entry_t typedef {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH, push/pop, flush, count, full/empty.
- inst_fetch holds only the PC register and the push/pop/redirect control.

## Test plan
- Reset release, RESET_PC = 0, ROM holds word k = 32'h1000_0000+k, id_ready = 1 → id_pc = 0, 4, 8… on consecutive cycles; id_inst = 32'h1000_0000, …_0001, …_0002.
- id_ready = 0 for 10 cycles, DEPTH = 4 → fifo_count saturates at 4; rom_addr holds at 0x10; asserting id_ready then delivers PCs 0x0–0xC in order, then 0x10.
- Redirect to 32'h0000_0203 while 3 entries buffered → id_valid = 0 that cycle; fifo_count = 0 next; next delivered id_pc = 0x200 with ROM word 128.
- PC at 32'hFFFF_FFFC with fetch_en = 1 → next rom_addr = 0; the FFFF_FFFC entry is delivered before the PC-0 entry.
- Full FIFO with simultaneous pop and fetch_en → count drops to 3 and PC is unchanged; the next cycle pushes.
- rst_n pulsed low mid-stream with 2 entries buffered → id_valid = 0 and rom_addr = RESET_PC immediately, without a clock edge.
